issue_select: RTL and testbench
===============================

ISSUE_SELECT -- requirements
Module: issue_select

Interface
REQ-001 The module SHALL take parameter Size, default 16, as the number of queue slots observed; Size SHALL be a power of two >= 2.
REQ-002 The module SHALL take parameter type T, default logic, as the queue entry type.
REQ-003 The module SHALL define localparam Width = $clog2(Size).
REQ-004 clk_ni  input  1  clock; all registers SHALL update on its falling edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 size_i  input  Width+1  number of valid queue slots; slots 0..size_i-1 are valid, slot 0 oldest.
REQ-007 entries_i  input  T[Size]  queue slot contents.
REQ-008 ready_i  input  1[Size]  per-slot operands-ready flag from the scoreboard.
REQ-009 flush_i  input  1  discard the buffered issue entries and suppress selection this cycle.
REQ-010 pop_o  output  1[Size]  per-slot pop request to the queue, at most one bit set.
REQ-011 issue_valid_o  output  1  issue_data_o holds a valid entry.
REQ-012 issue_ready_i  input  1  execution unit accepts issue_data_o this cycle.
REQ-013 issue_data_o  output  T  entry offered to the execution unit.
REQ-014 issue_count_o  output  32  number of accepted issues since reset.

Function
REQ-015 Candidate slot i SHALL be eligible when i < size_i and ready_i[i] = 1.
REQ-016 The selected slot SHALL be the lowest-index eligible slot (oldest-first).
REQ-017 The module SHALL hold a two-entry output buffer (head register plus skid register) with occupancy count 0, 1 or 2, states EMPTY, ONE, FULL.
REQ-018 take = eligible slot exists AND flush_i = 0 AND (count < 2 OR (issue_valid_o AND issue_ready_i)).
REQ-019 pop_o SHALL be combinational: one-hot on the selected slot when take = 1, all zero otherwise.
REQ-020 On a falling edge with take = 1 the module SHALL capture entries_i[selected] into the buffer tail, so the entry appears on issue_data_o no earlier than the next cycle (latency 1 when EMPTY).
REQ-021 A transfer SHALL occur on a falling edge where issue_valid_o = 1 and issue_ready_i = 1; the head SHALL then be replaced by the skid entry, or by the newly taken entry if the skid is empty.
REQ-022 issue_valid_o SHALL equal (count != 0); issue_data_o SHALL be the head register and SHALL stay stable while issue_valid_o = 1 and issue_ready_i = 0.
REQ-023 Simultaneous transfer and take in FULL SHALL keep count at 2 with order preserved (skid to head, new entry to skid).
REQ-024 Transfer and take in ONE SHALL keep count at 1 with the new entry in head.
REQ-025 flush_i = 1 SHALL force count to 0 on that edge, drive pop_o all zero, and not count any transfer in that cycle.
REQ-026 size_i = 0 SHALL produce no pop, regardless of ready_i.
REQ-027 issue_count_o SHALL increment by 1 per transfer and wrap modulo 2^32.
REQ-028 Entries SHALL leave the buffer in the exact order they were taken.

Reset
REQ-029 With rst_i = 1 at a falling edge, count SHALL become 0, issue_count_o 0, and pop_o SHALL be all zero while rst_i = 1.
REQ-030 Reset asserted mid-operation SHALL discard buffered entries without a transfer; head/skid data contents need not be cleared.

Structure
REQ-031 The occupancy-state enum (EMPTY, ONE, FULL) SHALL live in the shared core package.
REQ-032 The oldest-first select SHALL be a sub-module priority_select (Size-bit request in, one-hot grant plus Width-bit index and found flag out).
REQ-033 Expected size: 120-400 lines RTL.

Verification
REQ-034 Size=16, size_i=3, ready_i slots 1,2 set, buffer EMPTY -> pop_o = slot 1 only; next cycle issue_valid_o=1, issue_data_o=entries_i[1].
REQ-035 size_i=2, ready_i only slot 5 set -> pop_o all zero, issue_valid_o stays 0.
REQ-036 issue_ready_i=0 for 4 cycles with slot 0 always eligible -> exactly 2 pops then pop_o zero; head data unchanged; count FULL.
REQ-037 FULL, issue_ready_i=1, slot 0 eligible -> one pop per cycle, transfers in take order, issue_count_o +1 per cycle.
REQ-038 FULL, flush_i=1 with issue_ready_i=1 -> pop_o zero, issue_valid_o=0 next cycle, issue_count_o unchanged.
REQ-039 rst_i=1 while FULL -> next cycle issue_valid_o=0, issue_count_o=0, pop_o zero.

Source files
------------

// File: rtl/issue_select_pkg.sv
// Shared definitions for the issue-select block: output buffer occupancy states.
package issue_select_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/issue_select_priority_select.sv
// Oldest-first select: the lowest-index request wins; returns one-hot grant and index.
module priority_select #(
  parameter int unsigned Size  = 16,
  localparam int unsigned Width = $clog2(Size)
) (
  input  logic [Size-1:0]  req,
  output logic [Size-1:0]  grant,
  output logic [Width-1:0] idx,
  output logic             found
);

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < int'(Size); i++) begin
      if (req[i] && !found) begin
        grant[i] = 1'b1;
        idx      = Width'(i);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/issue_select.sv
// Picks the oldest ready queue slot and feeds it through a two-entry (head + skid)
// buffer to the execution unit. All state updates on the falling edge of clk_ni.
module issue_select
  import issue_select_pkg::*;
#(
  parameter int unsigned Size  = 16,
  parameter type         T     = logic,
  localparam int unsigned Width = $clog2(Size)
) (
  input  logic            clk_ni,
  input  logic            rst_i,
  input  logic [Width:0]  size_i,
  input  T                entries_i [Size],
  input  logic [Size-1:0] ready_i,
  input  logic            flush_i,
  output logic [Size-1:0] pop_o,
  output logic            issue_valid_o,
  input  logic            issue_ready_i,
  output T                issue_data_o,
  output logic [31:0]     issue_count_o
);

  occ_e             state, state_next;
  T                 head_q, skid_q;
  logic [Size-1:0]  eligible;
  logic [Size-1:0]  grant;
  logic [Width-1:0] sel_idx;
  logic             found;
  logic             handshake, xfer, take;
  logic             head_load, head_from_skid, skid_load;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < int'(Size); i++) begin
      eligible[i] = ready_i[i] && ((Width+1)'(i) < size_i);
    end
  end

  priority_select #(.Size(Size)) u_select (
    .req   (eligible),
    .grant (grant),
    .idx   (sel_idx),
    .found (found)
  );

  assign issue_valid_o = (state != EMPTY);
  assign issue_data_o  = head_q;
  assign handshake     = issue_valid_o && issue_ready_i;
  // Flush and reset both squash the handshake so no issue is counted.
  assign xfer          = handshake && !flush_i && !rst_i;
  assign take          = found && !flush_i && !rst_i && ((state != FULL) || handshake);
  assign pop_o         = take ? grant : '0;

  always_comb begin
    state_next     = state;
    head_load      = 1'b0;
    head_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (rst_i || flush_i) begin
      state_next = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (take) begin
            state_next = ONE;
            head_load  = 1'b1;
          end
        end
        ONE: begin
          if (xfer && take) begin
            head_load = 1'b1;
          end else if (xfer) begin
            state_next = EMPTY;
          end else if (take) begin
            state_next = FULL;
            skid_load  = 1'b1;
          end
        end
        FULL: begin
          if (xfer) begin
            head_load      = 1'b1;
            head_from_skid = 1'b1;
            if (take) begin
              skid_load = 1'b1;
            end else begin
              state_next = ONE;
            end
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(negedge clk_ni) begin
    if (rst_i) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Data registers carry no reset; occupancy alone decides what is valid.
  always_ff @(negedge clk_ni) begin
    if (head_load) begin
      head_q <= head_from_skid ? skid_q : entries_i[sel_idx];
    end
    if (skid_load) begin
      skid_q <= entries_i[sel_idx];
    end
  end

  always_ff @(negedge clk_ni) begin
    if (rst_i) begin
      issue_count_o <= '0;
    end else if (xfer) begin
      issue_count_o <= issue_count_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_issue_select.sv
// Randomized and directed bench for issue_select against a queue-based reference model.
module tb_issue_select;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  size;
  logic [7:0]  entries [N];
  logic [N-1:0] ready;
  logic        flush;
  logic [N-1:0] pop;
  logic        issue_valid;
  logic        issue_ready;
  logic [7:0]  issue_data;
  logic [31:0] issue_count;

  int errors = 0;
  int checks = 0;

  logic [7:0]  mq[$];
  logic [31:0] mcount = 0;
  int          pops_seen;

  always #5 clk = ~clk;

  issue_select #(.Size(N), .T(logic [7:0])) dut (
    .clk_ni        (clk),
    .rst_i         (rst),
    .size_i        (size),
    .entries_i     (entries),
    .ready_i       (ready),
    .flush_i       (flush),
    .pop_o         (pop),
    .issue_valid_o (issue_valid),
    .issue_ready_i (issue_ready),
    .issue_data_o  (issue_data),
    .issue_count_o (issue_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: drive at the rising edge, check combinational and registered outputs,
  // then let the falling edge update DUT and model.
  task automatic step(input int sz, input logic [N-1:0] rdy, input logic fl,
                      input logic ir, input logic rs);
    int          first;
    logic        tk, xf;
    logic [N-1:0] exp_pop;
    @(posedge clk);
    size        = 5'(sz);
    ready       = rdy;
    flush       = fl;
    issue_ready = ir;
    rst         = rs;
    for (int i = 0; i < N; i++) entries[i] = 8'($urandom);
    #1;
    first = -1;
    for (int i = 0; i < sz && i < N; i++) begin
      if (rdy[i] && first < 0) first = i;
    end
    xf = (mq.size() > 0) && ir && !fl && !rs;
    tk = (first >= 0) && !fl && !rs && (mq.size() < 2 || (mq.size() > 0 && ir));
    exp_pop = '0;
    if (tk) exp_pop[first] = 1'b1;
    chk("pop", 32'(pop), 32'(exp_pop));
    chk("valid", 32'(issue_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("data", 32'(issue_data), 32'(mq[0]));
    chk("count", issue_count, mcount);
    if (pop != '0) pops_seen++;
    @(negedge clk);
    #1;
    if (rs) begin
      mq.delete();
      mcount = 0;
    end else if (fl) begin
      mq.delete();
    end else begin
      if (xf) begin
        void'(mq.pop_front());
        mcount++;
      end
      if (tk) mq.push_back(entries[first]);
    end
  endtask

  logic [7:0] saved;
  logic [31:0] cnt_before;

  initial begin
    rst = 1'b1; size = '0; ready = '0; flush = 1'b0; issue_ready = 1'b0;
    for (int i = 0; i < N; i++) entries[i] = '0;
    repeat (2) @(negedge clk);

    step(0, '0, 0, 0, 1);
    chk("reset_valid", 32'(issue_valid), 32'd0);
    chk("reset_count", issue_count, 32'd0);

    // oldest-first select with latency 1 from EMPTY
    @(posedge clk);
    step(3, 16'h0006, 0, 0, 0);
    chk("d034_pop", 32'(pop), 32'h2);
    saved = entries[1];
    chk("d034_valid", 32'(issue_valid), 32'd1);
    chk("d034_data", 32'(issue_data), 32'(saved));

    // slot outside size_i is never eligible
    step(0, '0, 0, 0, 1);
    step(2, 16'h0020, 0, 0, 0);
    step(2, 16'h0020, 0, 0, 0);
    chk("d035_valid", 32'(issue_valid), 32'd0);
    step(0, 16'hFFFF, 0, 0, 0);

    // stall fills FULL after exactly two pops, head stable
    step(0, '0, 0, 0, 1);
    pops_seen = 0;
    step(16, 16'h0001, 0, 0, 0);
    saved = mq[0];
    repeat (3) step(16, 16'h0001, 0, 0, 0);
    chk("d036_pops", 32'(pops_seen), 32'd2);
    chk("d036_head", 32'(issue_data), 32'(saved));

    // streaming from FULL: one issue per cycle
    cnt_before = issue_count;
    repeat (4) step(16, 16'h0001, 0, 1, 0);
    chk("d037_count", issue_count, cnt_before + 32'd4);

    // flush while FULL with ready high
    step(16, 16'h0001, 0, 0, 0);
    cnt_before = issue_count;
    step(16, 16'h0001, 1, 1, 0);
    chk("d038_valid", 32'(issue_valid), 32'd0);
    chk("d038_count", issue_count, cnt_before);

    // reset while FULL
    repeat (2) step(16, 16'hFFFF, 0, 0, 0);
    step(16, 16'hFFFF, 0, 1, 1);
    chk("d039_valid", 32'(issue_valid), 32'd0);
    chk("d039_count", issue_count, 32'd0);

    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, N),
           N'($urandom) & N'($urandom),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 99) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
